voice_scheduler: RTL

Time-multiplexes the single shared sine lookup table across `NUM_VOICES` phase-accumulator voices and sums their outputs into one signed PCM sample per audio frame. It sits between the sine table and the serial audio output stage. The serializer pulses `frame_req` once per LR frame, and this block answers with one `sample` / `sample_valid` pair. Per-voice frequency and enable are written through a simple register port.

---
 rtl/synth_pkg.sv | 26 ++
 rtl/voice_regfile.sv | 63 ++++++
 rtl/voice_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared constants and types for the voice scheduler slice.
//   NUM_VOICES / *_W : default geometry of the scheduler and sine table
//   TBL_MID          : offset-binary midpoint of the sine table data
//   sched_state_t    : scheduler FSM states
// -----------------------------------------------------------------------------
package synth_pkg;

  localparam int NUM_VOICES = 4;
  localparam int PHASE_W    = 16;
  localparam int TBL_AW     = 8;
  localparam int TBL_DW     = 7;
  localparam int SAMPLE_W   = 16;

  // Table words are unsigned with this value representing zero amplitude.
  localparam int TBL_MID    = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/voice_regfile.sv
// -----------------------------------------------------------------------------
// voice_regfile
// Per-voice phase increment, enable and phase accumulator registers.
//   clk, rst_n            : clock, async active-low reset
//   cfg_we/voice/inc/en   : configuration write port
//   vidx                  : voice currently served by the scheduler
//   advance               : step phase[vidx] by inc[vidx] (if enabled)
//   rd_phase, rd_en       : phase / enable of voice vidx (pre-update values)
// -----------------------------------------------------------------------------
module voice_regfile
  import synth_pkg::*;
#(
  parameter  int NUM_VOICES = synth_pkg::NUM_VOICES,
  parameter  int PHASE_W    = synth_pkg::PHASE_W,
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [VW-1:0]      cfg_voice,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic               cfg_en,
  input  logic [VW-1:0]      vidx,
  input  logic               advance,
  output logic [PHASE_W-1:0] rd_phase,
  output logic               rd_en
);

  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] inc_q   [NUM_VOICES];
  logic               en_q    [NUM_VOICES];

  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, so a read in the same cycle always sees old state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these arrays are small register files, not RAM macros, so they
      // are reset explicitly; a disabled voice must start at phase 0.
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
        en_q[i]    <= 1'b0;
      end
    end else begin
      if (advance && en_q[vidx]) begin
        phase_q[vidx] <= phase_q[vidx] + inc_q[vidx];
      end
      // Placed after the advance so a disabling write wins over a
      // same-cycle phase step and the voice lands at phase 0.
      if (cfg_we) begin
        inc_q[cfg_voice] <= cfg_inc;
        en_q[cfg_voice]  <= cfg_en;
        if (!cfg_en) begin
          phase_q[cfg_voice] <= '0;
        end
      end
    end
  end

  assign rd_phase = phase_q[vidx];
  assign rd_en    = en_q[vidx];

endmodule

// File: rtl/voice_scheduler.sv
// -----------------------------------------------------------------------------
// voice_scheduler
// Shares one sine table among NUM_VOICES phase-accumulator voices and mixes
// them into one signed sample per frame request.
//   clk, rst_n        : clock, async active-low reset
//   frame_req         : one-cycle request for the next mixed sample
//   cfg_*             : per-voice increment / enable write port
//   tbl_addr/tbl_data : sine table read port (data one cycle after address)
//   sample/_valid     : registered mixed sample and its one-cycle strobe
//   busy              : frame in progress
//   overrun           : sticky, request arrived while busy
// -----------------------------------------------------------------------------
module voice_scheduler
  import synth_pkg::*;
#(
  parameter  int NUM_VOICES = synth_pkg::NUM_VOICES,
  parameter  int PHASE_W    = synth_pkg::PHASE_W,
  parameter  int TBL_AW     = synth_pkg::TBL_AW,
  parameter  int TBL_DW     = synth_pkg::TBL_DW,
  parameter  int SAMPLE_W   = synth_pkg::SAMPLE_W,
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_req,
  input  logic                cfg_we,
  input  logic [VW-1:0]       cfg_voice,
  input  logic [PHASE_W-1:0]  cfg_inc,
  input  logic                cfg_en,
  output logic [TBL_AW-1:0]   tbl_addr,
  input  logic [TBL_DW-1:0]   tbl_data,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                busy,
  output logic                overrun
);

  // Accumulator grows by log2(voices) bits so the full sum never overflows.
  localparam int ACC_W = TBL_DW + VW;
  localparam int SHIFT = SAMPLE_W - ACC_W;
  localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);
  localparam logic signed [TBL_DW:0] MID = (TBL_DW + 1)'(TBL_MID);

  sched_state_t state_q, state_d;
  logic [VW-1:0]            vidx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [PHASE_W-1:0]       rd_phase;
  logic                     rd_en;
  logic signed [TBL_DW:0]   tap;

  voice_regfile #(
    .NUM_VOICES (NUM_VOICES),
    .PHASE_W    (PHASE_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_voice (cfg_voice),
    .cfg_inc   (cfg_inc),
    .cfg_en    (cfg_en),
    .vidx      (vidx_q),
    .advance   (state_q == FETCH),
    .rd_phase  (rd_phase),
    .rd_en     (rd_en)
  );

  // The address goes out in FETCH with the pre-update phase; the data
  // returns in the following ACCUM cycle.
  assign tbl_addr = rd_phase[PHASE_W-1 -: TBL_AW];
  assign busy     = (state_q != IDLE);
  assign tap      = $signed({1'b0, tbl_data}) - MID;

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_req) state_d = FETCH;
      FETCH:   state_d = ACCUM;
      ACCUM:   state_d = (vidx_q == LAST) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vidx_q       <= '0;
      acc_q        <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_valid <= (state_q == DONE);

      // Requests during DONE count as busy too; only IDLE starts a frame.
      if (frame_req && state_q != IDLE) begin
        overrun <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (frame_req) begin
            vidx_q <= '0;
            acc_q  <= '0;
          end
        end
        ACCUM: begin
          if (rd_en) begin
            acc_q <= acc_q + ACC_W'(tap);
          end
          if (vidx_q != LAST) begin
            vidx_q <= vidx_q + VW'(1);
          end
        end
        DONE: begin
          // Sign-extend to the sample width, then scale to full range.
          sample <= SAMPLE_W'(acc_q) <<< SHIFT;
          vidx_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
